// File: rtl/posit_pkg.sv
// Shared definitions for the posit multiplier normalise/encode slice.
// Holds the default word geometry, the derived internal widths, the special
// posit encodings and the payload carried from the normalise stage to the
// encode stage.
package posit_pkg;

    localparam int unsigned POSIT_WIDTH = 8;
    localparam int unsigned POSIT_EXP   = 2;

    // Signed width of a single operand's regime value.
    localparam int unsigned POSIT_REGI  = $clog2(POSIT_WIDTH) + 1;
    // Stored fraction width per operand.
    localparam int unsigned POSIT_MTS   = POSIT_WIDTH - 3 - POSIT_EXP;
    // Signed internal scale width.
    localparam int unsigned POSIT_SCL   = POSIT_REGI + POSIT_EXP + 2;
    // Product fraction width once the leading one is dropped.
    localparam int unsigned POSIT_FRW   = 2 * (POSIT_MTS + 1) - 1;

    localparam logic [POSIT_WIDTH-1:0] POSIT_NAR  = {1'b1, {(POSIT_WIDTH-1){1'b0}}};
    localparam logic [POSIT_WIDTH-1:0] POSIT_ZERO = '0;

    typedef struct packed {
        logic                        sign;
        logic signed [POSIT_SCL-1:0] scale;
        logic [POSIT_FRW-1:0]        fraction;
        logic                        zero;
        logic                        nar;
    } stage_t;

endpackage

// File: rtl/posit_regime_enc.sv
// Combinational posit encoder: turns a clamped scale, a normalised fraction
// and a sign into a WIDTH-bit posit word.
//
// Ports:
//   scale    in   SCL    clamped total scale (signed)
//   fraction in   FRW    fraction bits below the hidden one
//   sign     in   1      result sign
//   posit    out  WIDTH  encoded posit (rounded, saturated, signed)
//
// Build option: POSIT_MULT_NORM_ROUND_RNE_EN selects round-to-nearest-even;
// without it the magnitude is truncated.
module posit_regime_enc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned EXP   = 2,
    parameter int unsigned SCL   = 8,
    parameter int unsigned FRW   = 7
) (
    input  logic signed [SCL-1:0] scale,
    input  logic [FRW-1:0]        fraction,
    input  logic                  sign,
    output logic [WIDTH-1:0]      posit
);

    // The unshifted body is {regime seed, e, fraction} padded with WIDTH zeros,
    // so no bit is lost by the largest regime shift and every discarded bit
    // remains available for rounding.
    localparam int unsigned VW   = 2 + EXP + FRW + WIDTH;
    localparam int unsigned DROP = VW - (WIDTH - 1);

    logic signed [SCL-1:0] k;
    logic [EXP-1:0]        e;
    logic [SCL-1:0]        sh;
    logic [VW-1:0]         base;
    logic [VW-1:0]         shifted;
    logic [WIDTH-2:0]      mag;
    logic [WIDTH-2:0]      mag_sat;
    logic [WIDTH-1:0]      sum;
    logic [WIDTH-1:0]      word;
    logic                  round_up;
`ifdef POSIT_MULT_NORM_ROUND_RNE_EN
    logic [DROP-1:0]       dropped;
    logic                  guard;
    logic                  sticky;
`endif

    always_comb begin
        k        = scale >>> EXP;
        e        = scale[EXP-1:0];
        sh       = '0;
        base     = '0;
        shifted  = '0;
        round_up = 1'b0;

        // k >= 0: seed "10" arithmetically shifted by k yields k+1 ones then 0.
        // k <  0: seed "01" logically shifted by -k-1 (= ~k) yields -k zeros then 1.
        if (k >= 0) begin
            base    = {2'b10, e, fraction, {WIDTH{1'b0}}};
            sh      = k;
            shifted = $signed(base) >>> sh;
        end else begin
            base    = {2'b01, e, fraction, {WIDTH{1'b0}}};
            sh      = ~k;
            shifted = base >> sh;
        end

        mag = (WIDTH-1)'(shifted >> DROP);

`ifdef POSIT_MULT_NORM_ROUND_RNE_EN
        dropped  = DROP'(shifted);
        guard    = dropped[DROP-1];
        sticky   = |dropped[DROP-2:0];
        round_up = guard & (sticky | mag[0]);
`endif

        sum     = {1'b0, mag} + WIDTH'(round_up);
        mag_sat = sum[WIDTH-1] ? '1 : sum[WIDTH-2:0];
        if (mag_sat == '0) begin
            mag_sat = (WIDTH-1)'(1);
        end

        word  = {1'b0, mag_sat};
        posit = sign ? -word : word;
    end

endmodule

// File: rtl/posit_mult_norm.sv
// Posit multiplier back end: normalises the raw mantissa product, forms and
// clamps the total scale, and re-encodes a WIDTH-bit posit through a
// two-stage valid/ready pipeline.
//
// Ports:
//   clk_i     in   1           clock, rising edge
//   rst_i     in   1           synchronous active-high reset
//   vld_i     in   1           product fields valid
//   rdy_o     out  1           stage can accept
//   sign_m    in   1           product sign
//   regi_sum  in   REGI+1      signed sum of operand regimes
//   exp_m     in   EXP+1       exponent sum
//   mts_m     in   2*(MTS+1)   mantissa product (01.xxxx or 1x.xxxx)
//   zero_i    in   1           either operand zero
//   nar_i     in   1           either operand NaR (wins over zero_i)
//   posit_o   out  WIDTH       encoded product
//   vld_o     out  1           posit_o valid
//   rdy_i     in   1           consumer ready
//
// Build option: POSIT_MULT_NORM_ROUND_RNE_EN selects round-to-nearest-even
// in the encoder; otherwise the magnitude is truncated.
module posit_mult_norm
    import posit_pkg::*;
#(
    parameter int unsigned WIDTH = POSIT_WIDTH,
    parameter int unsigned EXP   = POSIT_EXP,
    parameter int unsigned REGI  = $clog2(WIDTH) + 1,
    parameter int unsigned MTS   = WIDTH - 3 - EXP
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  vld_i,
    output logic                  rdy_o,
    input  logic                  sign_m,
    input  logic signed [REGI:0]  regi_sum,
    input  logic [EXP:0]          exp_m,
    input  logic [2*(MTS+1)-1:0]  mts_m,
    input  logic                  zero_i,
    input  logic                  nar_i,
    output logic [WIDTH-1:0]      posit_o,
    output logic                  vld_o,
    input  logic                  rdy_i
);

    localparam int unsigned SCL = REGI + EXP + 2;
    localparam int unsigned MSB = 2 * (MTS + 1) - 1;
    localparam int unsigned FRW = MSB;

    localparam logic signed [SCL-1:0] SCALE_MAX = SCL'((WIDTH - 2) << EXP);
    localparam logic signed [SCL-1:0] SCALE_MIN = -SCALE_MAX;

    stage_t                s1;
    stage_t                s1_next;
    logic                  s1_vld;
    logic [WIDTH-1:0]      posit_q;
    logic                  vld_q;
    logic                  advance;
    logic                  carry;
    logic signed [SCL-1:0] regi_ext;
    logic signed [SCL-1:0] scale_clamped;
    logic [WIDTH-1:0]      enc_word;
    logic [WIDTH-1:0]      posit_next;

    // Only a valid, unconsumed result blocks the pipe; bubbles never stall.
    assign advance = !(vld_q && !rdy_i);

    // Stage 1: normalise the product so the hidden one is dropped.
    always_comb begin
        s1_next  = '0;
        carry    = 1'b0;
        regi_ext = SCL'(regi_sum);

        s1_next.sign = sign_m;
        s1_next.zero = zero_i;
        s1_next.nar  = nar_i;

        if (mts_m[MSB]) begin
            s1_next.fraction = mts_m[MSB-1:0];
            carry            = 1'b1;
        end else begin
            s1_next.fraction = {mts_m[MSB-2:0], 1'b0};
        end

        s1_next.scale = (regi_ext <<< EXP) + $signed(SCL'(exp_m)) + $signed(SCL'(carry));
    end

    // Stage 2: clamp to the representable range, encode, apply specials.
    always_comb begin
        scale_clamped = s1.scale;
        if (s1.scale > SCALE_MAX) begin
            scale_clamped = SCALE_MAX;
        end else if (s1.scale < SCALE_MIN) begin
            scale_clamped = SCALE_MIN;
        end
    end

    posit_regime_enc #(
        .WIDTH (WIDTH),
        .EXP   (EXP),
        .SCL   (SCL),
        .FRW   (FRW)
    ) u_enc (
        .scale    (scale_clamped),
        .fraction (s1.fraction),
        .sign     (s1.sign),
        .posit    (enc_word)
    );

    always_comb begin
        posit_next = enc_word;
        if (s1.nar) begin
            posit_next = POSIT_NAR;
        end else if (s1.zero) begin
            posit_next = POSIT_ZERO;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1      <= '0;
            s1_vld  <= 1'b0;
            posit_q <= '0;
            vld_q   <= 1'b0;
        end else if (advance) begin
            s1      <= s1_next;
            s1_vld  <= vld_i;
            posit_q <= posit_next;
            vld_q   <= s1_vld;
        end
    end

    assign rdy_o   = advance;
    assign posit_o = posit_q;
    assign vld_o   = vld_q;

endmodule
